// File: rtl/ddr_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_sram_ctrl_pkg
// Brief    : Shared FSM encoding and request-entry sizing for the SRAM controller
// Revision : 1.0 - initial release
// ============================================================================
package ddr_sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_TURN    = 3'd4
    } state_t;

    localparam int c_fifo_depth = 2;

    // Request entry layout, MSB first: {write, address, data}
    function automatic int entry_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sram_req_fifo
// Brief    : Two-entry request queue with fall-through head when empty
// Revision : 1.0 - initial release
// ============================================================================
module sram_req_fifo
    import ddr_sram_ctrl_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_head_valid,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [c_fifo_depth];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;

    assign o_full       = (r_count == 2'd2);
    assign o_empty      = (r_count == 2'd0);
    // An empty queue presents the incoming request so an idle consumer can take it on the accept edge
    assign o_head_valid = !o_empty || i_push;
    assign o_head       = o_empty ? i_data : r_mem[r_rd_ptr];

    assign w_push   = i_push && !o_full;
    assign w_pop    = i_pop && o_head_valid;
    assign w_bypass = o_empty && w_push && w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < c_fifo_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!w_bypass) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ddr_sram_ctrl
// Brief    : Queued single-port SRAM controller with read-to-write bus turnaround
// Revision : 1.0 - initial release
// ============================================================================
module ddr_sram_ctrl
    import ddr_sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [ADDR_WIDTH-1:0] ReqAddress,
    input  logic [DATA_WIDTH-1:0] ReqData,
    output logic                  RdValid,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  Busy,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  Enable,
    output logic                  Read,
    output logic                  Write,
    output logic [DATA_WIDTH-1:0] MemDataOut,
    output logic                  MemDataOe,
    input  logic [DATA_WIDTH-1:0] MemDataIn
);

    localparam int c_entry_w = entry_width(ADDR_WIDTH, DATA_WIDTH);

    state_t                r_state;
    logic                  r_wr;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_head_valid;
    logic                  w_pop;
    logic [c_entry_w-1:0]  w_head;
    logic                  w_head_wr;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_data;

    sram_req_fifo #(
        .WIDTH(c_entry_w)
    ) u_fifo (
        .clk          (Clock),
        .rst_n        (nReset),
        .i_push       (ReqValid),
        .i_data       ({ReqWrite, ReqAddress, ReqData}),
        .i_pop        (w_pop),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_head_valid (w_head_valid),
        .o_head       (w_head)
    );

    assign {w_head_wr, w_head_addr, w_head_data} = w_head;
    assign ReqReady = !w_full;
    assign Busy     = !w_empty || (r_state != ST_IDLE);

    // A pop always launches the popped request into SETUP; a read followed by a write waits one TURN cycle
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE:    w_pop = w_head_valid;
            ST_ACCESS:  w_pop = r_wr && w_head_valid;
            ST_CAPTURE: w_pop = w_head_valid && !w_head_wr;
            ST_TURN:    w_pop = w_head_valid;
            default:    w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state    <= ST_IDLE;
            r_wr       <= 1'b0;
            RdValid    <= 1'b0;
            RdData     <= '0;
            Address    <= '0;
            Enable     <= 1'b0;
            Read       <= 1'b0;
            Write      <= 1'b0;
            MemDataOut <= '0;
            MemDataOe  <= 1'b0;
        end else begin
            RdValid <= 1'b0;
            if (w_pop) begin
                r_state   <= ST_SETUP;
                r_wr      <= w_head_wr;
                Address   <= w_head_addr;
                MemDataOe <= w_head_wr;
                Enable    <= 1'b0;
                Read      <= 1'b0;
                Write     <= 1'b0;
                if (w_head_wr) begin
                    MemDataOut <= w_head_data;
                end
            end
            case (r_state)
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                    Enable  <= 1'b1;
                    Read    <= !r_wr;
                    Write   <= r_wr;
                end
                ST_ACCESS: begin
                    if (!r_wr) begin
                        r_state <= ST_CAPTURE;
                    end else if (!w_pop) begin
                        r_state   <= ST_IDLE;
                        Enable    <= 1'b0;
                        Write     <= 1'b0;
                        MemDataOe <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    RdData  <= MemDataIn;
                    RdValid <= 1'b1;
                    if (!w_pop) begin
                        r_state <= w_head_valid ? ST_TURN : ST_IDLE;
                        Enable  <= 1'b0;
                        Read    <= 1'b0;
                    end
                end
                ST_IDLE, ST_TURN: begin
                    if (!w_pop) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
